// File: rtl/cpu_run_controller.sv
// Run/halt/step/breakpoint sequencer for the CPU core: debounced board inputs
// drive a small FSM that gates the core with cpuEnable and counts executed cycles.

module cpu_run_debounce #(
  parameter int CYCLES = 4
) (
  input  logic clock,
  input  logic rst,
  input  logic raw,
  output logic rise
);
  localparam int CW = $clog2(CYCLES + 1);

  logic [1:0]    sync_q, sync_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  logic          level_dly_q, level_dly_d;

  // Level flips only after the synchronized input has disagreed with it for
  // CYCLES consecutive clocks; any agreement in between restarts the count.
  always_comb begin
    sync_d      = {sync_q[0], raw};
    level_d     = level_q;
    level_dly_d = level_q;
    cnt_d       = '0;
    if (sync_q[1] != level_q) begin
      if (cnt_q == CW'(CYCLES - 1)) level_d = sync_q[1];
      else                          cnt_d   = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      sync_q      <= '0;
      cnt_q       <= '0;
      level_q     <= 1'b0;
      level_dly_q <= 1'b0;
    end else begin
      sync_q      <= sync_d;
      cnt_q       <= cnt_d;
      level_q     <= level_d;
      level_dly_q <= level_dly_d;
    end
  end

  assign rise = level_q & ~level_dly_q;
endmodule

module cpu_run_controller #(
  parameter int REGISTER_WIDTH  = 8,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int RESET_CYCLES    = 4,
  parameter int COUNT_WIDTH     = 16
) (
  input  logic                      clock,
  input  logic                      isReset,
  input  logic                      switch,
  input  logic                      stepButton,
  input  logic [REGISTER_WIDTH-1:0] register1Value,
  input  logic [REGISTER_WIDTH-1:0] breakpointValue,
  input  logic                      breakpointEnable,
  output logic                      cpuEnable,
  output logic                      cpuReset,
  output logic [2:0]                state,
  output logic [COUNT_WIDTH-1:0]    cycleCount
);
  localparam int RW = $clog2(RESET_CYCLES + 1);

  typedef enum logic [2:0] {
    S_RESET_HOLD = 3'd0,
    S_HALTED     = 3'd1,
    S_RUNNING    = 3'd2,
    S_STEP       = 3'd3,
    S_BREAK      = 3'd4
  } state_e;

  state_e                 state_q, state_d;
  logic [RW-1:0]          rst_cnt_q, rst_cnt_d;
  logic [COUNT_WIDTH-1:0] cycle_count_q, cycle_count_d;
  logic                   bp_armed_q, bp_armed_d;
  logic [1:0]             pulse;
  logic                   toggle_pulse, step_pulse;
  logic                   bp_eq, bp_hit;

  // Lane 0 = run/halt switch, lane 1 = step button.
  cpu_run_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db [1:0] (
    .clock (clock),
    .rst   (isReset),
    .raw   ({stepButton, switch}),
    .rise  (pulse)
  );

  assign toggle_pulse = pulse[0];
  assign step_pulse   = pulse[1];

  assign bp_eq  = (register1Value == breakpointValue);
  assign bp_hit = breakpointEnable & bp_armed_q & bp_eq;

  always_comb begin
    state_d       = state_q;
    rst_cnt_d     = rst_cnt_q;
    bp_armed_d    = bp_armed_q;
    cycle_count_d = cycle_count_q + COUNT_WIDTH'(cpuEnable);

    // Resuming from a break on the matching value disarms until the match clears.
    if (!breakpointEnable || !bp_eq)             bp_armed_d = 1'b1;
    else if (state_q == S_BREAK && toggle_pulse) bp_armed_d = 1'b0;

    unique case (state_q)
      S_RESET_HOLD: begin
        cycle_count_d = '0;
        if (rst_cnt_q == RW'(RESET_CYCLES - 1)) state_d   = S_HALTED;
        else                                    rst_cnt_d = rst_cnt_q + 1'b1;
      end
      S_HALTED: begin
        if (toggle_pulse)    state_d = S_RUNNING;
        else if (step_pulse) state_d = S_STEP;
      end
      S_RUNNING: begin
        if (toggle_pulse) state_d = S_HALTED;
        else if (bp_hit)  state_d = S_BREAK;
      end
      S_STEP:  state_d = S_HALTED;
      S_BREAK: begin
        if (toggle_pulse)    state_d = S_RUNNING;
        else if (step_pulse) state_d = S_STEP;
      end
      default: state_d = S_RESET_HOLD;
    endcase
  end

  always_ff @(posedge clock or posedge isReset) begin
    if (isReset) begin
      state_q       <= S_RESET_HOLD;
      rst_cnt_q     <= '0;
      cycle_count_q <= '0;
      bp_armed_q    <= 1'b1;
    end else begin
      state_q       <= state_d;
      rst_cnt_q     <= rst_cnt_d;
      cycle_count_q <= cycle_count_d;
      bp_armed_q    <= bp_armed_d;
    end
  end

  // The break cycle itself never executes, so the core cannot overrun the match.
  assign cpuEnable  = ((state_q == S_RUNNING) & ~bp_hit) | (state_q == S_STEP);
  assign cpuReset   = (state_q == S_RESET_HOLD);
  assign state      = state_q;
  assign cycleCount = cycle_count_q;
endmodule
